// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue and the dispatcher that consumes it.
package inst_queue_pkg;

    // Width of each instruction field (type/dest/src0/src1).
    localparam int INS_PART_WID = 4;

    // Opcodes carried in the type field; stored verbatim by the queue.
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_MULT  = 4'd2;
    localparam logic [3:0] OP_FETCH = 4'd3;
    localparam logic [3:0] OP_STORE = 4'd4;

    // One queued instruction as packed into a storage word (type in the top field).
    typedef struct packed {
        logic [INS_PART_WID-1:0] op;
        logic [INS_PART_WID-1:0] dest;
        logic [INS_PART_WID-1:0] src0;
        logic [INS_PART_WID-1:0] src1;
    } ins_t;

    // Number of entries retired this cycle; inst_2 can only go together with inst_1.
    function automatic logic [1:0] pop_count(input logic take_1, input logic take_2);
        if (!take_1) begin
            return 2'd0;
        end
        return take_2 ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction storage: one synchronous write port, two asynchronous read ports.
// The array carries no reset; validity is tracked by the occupancy count in the top level.
module inst_queue_mem #(
    parameter int DEPTH = 8,
    parameter int WID   = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WID-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
    output logic [WID-1:0]           rd_data_a,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
    output logic [WID-1:0]           rd_data_b
);

    logic [WID-1:0] store [DEPTH];

    // Capture the incoming instruction at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_addr] <= wr_data;
        end
    end

    // Both read ports are plain combinational lookups.
    always_comb begin
        rd_data_a = store[rd_addr_a];
        rd_data_b = store[rd_addr_b];
    end

endmodule

// File: rtl/inst_queue.sv
// Dual-issue in-order instruction queue feeding inst_dispatch.
// Presents the two oldest entries and retires one or two per cycle on the fetch strobes.
module inst_queue #(
    parameter int DEPTH        = 8,
    parameter int INS_PART_WID = inst_queue_pkg::INS_PART_WID
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INS_PART_WID-1:0]   in_type,
    input  logic [INS_PART_WID-1:0]   in_dest,
    input  logic [INS_PART_WID-1:0]   in_src0,
    input  logic [INS_PART_WID-1:0]   in_src1,
    output logic                      inst_1_valid,
    output logic [INS_PART_WID-1:0]   inst_1_type,
    output logic [INS_PART_WID-1:0]   inst_1_dest,
    output logic [INS_PART_WID-1:0]   inst_1_src0,
    output logic [INS_PART_WID-1:0]   inst_1_src1,
    input  logic                      inst_1_fetch,
    output logic                      inst_2_valid,
    output logic [INS_PART_WID-1:0]   inst_2_type,
    output logic [INS_PART_WID-1:0]   inst_2_dest,
    output logic [INS_PART_WID-1:0]   inst_2_src0,
    output logic [INS_PART_WID-1:0]   inst_2_src1,
    input  logic                      inst_2_fetch,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      proto_err
);

    import inst_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 4 * INS_PART_WID;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_2;
    logic [ENT_W-1:0] wr_word;
    logic [ENT_W-1:0] rd_word_1;
    logic [ENT_W-1:0] rd_word_2;

    logic             push;
    logic             take_1;
    logic             take_2;
    logic [1:0]       pop;
    logic             violation;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_next;

    // Status flags come only from registered occupancy, so nothing here sees the fetch inputs.
    always_comb begin
        in_ready     = (count < FULL_CNT);
        inst_1_valid = (count != '0);
        inst_2_valid = (count > CNT_W'(1));
        rd_ptr_2     = rd_ptr + PTR_W'(1);
    end

    // Decide what moves this cycle: push, how many pops, and whether the dispatcher misbehaved.
    always_comb begin
        push      = in_valid & in_ready;
        take_1    = inst_1_fetch & inst_1_valid;
        take_2    = take_1 & inst_2_fetch & inst_2_valid;
        pop       = pop_count(take_1, take_2);
        // Fetching an empty slot, or taking inst_2 without inst_1, is flagged but never retires anything extra.
        violation = (inst_1_fetch & ~inst_1_valid)
                  | (inst_2_fetch & ~inst_2_valid)
                  | (inst_2_fetch & ~inst_1_fetch);
        count_next  = count + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_next = rd_ptr + PTR_W'(pop);
        wr_ptr_next = wr_ptr + PTR_W'(push);
    end

    // Pointer, occupancy and sticky error state; flush clears the queue but leaves the error flag alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            proto_err <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            proto_err <= proto_err | violation;
        end
    end

    // Pack the incoming fields into one storage word, type in the top field.
    always_comb begin
        wr_word = {in_type, in_dest, in_src0, in_src1};
    end

    inst_queue_mem #(
        .DEPTH (DEPTH),
        .WID   (ENT_W)
    ) u_mem (
        .clk       (clk),
        .wr_en     (push & ~flush),
        .wr_addr   (wr_ptr),
        .wr_data   (wr_word),
        .rd_addr_a (rd_ptr),
        .rd_data_a (rd_word_1),
        .rd_addr_b (rd_ptr_2),
        .rd_data_b (rd_word_2)
    );

    // Unpack the two head entries, forcing zero on any slot that holds no live instruction.
    always_comb begin
        inst_1_type = '0;
        inst_1_dest = '0;
        inst_1_src0 = '0;
        inst_1_src1 = '0;
        inst_2_type = '0;
        inst_2_dest = '0;
        inst_2_src0 = '0;
        inst_2_src1 = '0;
        if (inst_1_valid) begin
            {inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1} = rd_word_1;
        end
        if (inst_2_valid) begin
            {inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1} = rd_word_2;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
module tb_inst_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_type, in_dest, in_src0, in_src1;
    logic       inst_1_valid, inst_2_valid;
    logic [3:0] inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1;
    logic [3:0] inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1;
    logic       inst_1_fetch, inst_2_fetch;
    logic [3:0] count;
    logic       proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    inst_queue #(.DEPTH(8), .INS_PART_WID(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_type      (in_type),
        .in_dest      (in_dest),
        .in_src0      (in_src0),
        .in_src1      (in_src1),
        .inst_1_valid (inst_1_valid),
        .inst_1_type  (inst_1_type),
        .inst_1_dest  (inst_1_dest),
        .inst_1_src0  (inst_1_src0),
        .inst_1_src1  (inst_1_src1),
        .inst_1_fetch (inst_1_fetch),
        .inst_2_valid (inst_2_valid),
        .inst_2_type  (inst_2_type),
        .inst_2_dest  (inst_2_dest),
        .inst_2_src0  (inst_2_src0),
        .inst_2_src1  (inst_2_src1),
        .inst_2_fetch (inst_2_fetch),
        .count        (count),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_type      = 4'd0;
        in_dest      = 4'd0;
        in_src0      = 4'd0;
        in_src1      = 4'd0;
        inst_1_fetch = 1'b0;
        inst_2_fetch = 1'b0;
    endtask

    task automatic offer(input logic [3:0] t, input logic [3:0] d, input logic [3:0] s0, input logic [3:0] s1);
        in_valid = 1'b1;
        in_type  = t;
        in_dest  = d;
        in_src0  = s0;
        in_src1  = s1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_checks++; if (inst_1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_v1: got %0b expected 0", inst_1_valid); end
        n_checks++; if (inst_2_valid !== 1'b0) begin n_fail++; $display("FAIL reset_v2: got %0b expected 0", inst_2_valid); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", proto_err); end
        n_checks++; if ({inst_1_type, inst_1_dest, inst_2_type, inst_2_dest} !== 16'h0) begin
            n_fail++; $display("FAIL reset_fields: got %h expected 0000", {inst_1_type, inst_1_dest, inst_2_type, inst_2_dest});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_release_count: got %0d expected 0", count); end
    endtask

    task automatic test_push_one();
        offer(4'd1, 4'd1, 4'd2, 4'd3);
        tick();
        idle_inputs();
        n_checks++; if (inst_1_valid !== 1'b1) begin n_fail++; $display("FAIL push1_v1: got %0b expected 1", inst_1_valid); end
        n_checks++; if ({inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1} !== 16'h1123) begin
            n_fail++; $display("FAIL push1_fields: got %h expected 1123", {inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1});
        end
        n_checks++; if (inst_2_valid !== 1'b0) begin n_fail++; $display("FAIL push1_v2: got %0b expected 0", inst_2_valid); end
        n_checks++; if (inst_2_dest !== 4'd0) begin n_fail++; $display("FAIL push1_slot2_zero: got %0d expected 0", inst_2_dest); end
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL push1_count: got %0d expected 1", count); end
    endtask

    task automatic test_fill_and_wrap();
        pulse_reset();
        // Entry i: type (i%4)+1, dest i, src0 i+1, src1 i+2.
        for (int i = 0; i < 8; i++) begin
            offer(4'((i % 4) + 1), 4'(i), 4'(i + 1), 4'(i + 2));
            tick();
        end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d expected 8", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %0b expected 0", in_ready); end
        // Ninth offer must be refused.
        offer(4'd4, 4'd15, 4'd15, 4'd15);
        tick();
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ninth_count: got %0d expected 8", count); end
        n_checks++; if ({inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1} !== 16'h1012) begin
            n_fail++; $display("FAIL full_inst1: got %h expected 1012", {inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1});
        end
        n_checks++; if ({inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1} !== 16'h2123) begin
            n_fail++; $display("FAIL full_inst2: got %h expected 2123", {inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1});
        end
        // Full: fetch both with push offered; push refused, pop 2 -> 6.
        inst_1_fetch = 1'b1;
        inst_2_fetch = 1'b1;
        offer(4'd4, 4'd8, 4'd0, 4'd0);
        tick();
        n_checks++; if (count !== 4'd6) begin n_fail++; $display("FAIL drain_c1_count: got %0d expected 6", count); end
        n_checks++; if (inst_1_dest !== 4'd2) begin n_fail++; $display("FAIL drain_c1_head: got %0d expected 2", inst_1_dest); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_c1_ready: got %0b expected 1", in_ready); end
        // Same offer (dest 8) now accepted, pop 2 -> 5.
        tick();
        n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL drain_c2_count: got %0d expected 5", count); end
        n_checks++; if (inst_1_dest !== 4'd4) begin n_fail++; $display("FAIL drain_c2_head: got %0d expected 4", inst_1_dest); end
        offer(4'd4, 4'd9, 4'd0, 4'd0);
        tick();
        n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL drain_c3_count: got %0d expected 4", count); end
        n_checks++; if (inst_1_dest !== 4'd6) begin n_fail++; $display("FAIL drain_c3_head: got %0d expected 6", inst_1_dest); end
        // Pops entries 6,7: rd_ptr wraps 7->0 where dest 8 was written.
        offer(4'd4, 4'd10, 4'd0, 4'd0);
        tick();
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", count); end
        n_checks++; if ({inst_1_type, inst_1_dest} !== 8'h48) begin n_fail++; $display("FAIL wrap_inst1: got %h expected 48", {inst_1_type, inst_1_dest}); end
        n_checks++; if (inst_2_dest !== 4'd9) begin n_fail++; $display("FAIL wrap_inst2: got %0d expected 9", inst_2_dest); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL tail_count: got %0d expected 1", count); end
        n_checks++; if (inst_1_dest !== 4'd10) begin n_fail++; $display("FAIL tail_head: got %0d expected 10", inst_1_dest); end
        n_checks++; if (inst_2_valid !== 1'b0) begin n_fail++; $display("FAIL tail_v2: got %0b expected 0", inst_2_valid); end
        inst_2_fetch = 1'b0;
        tick();
        idle_inputs();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL empty_count: got %0d expected 0", count); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL wrap_no_err: got %0b expected 0", proto_err); end
    endtask

    task automatic test_proto_err();
        pulse_reset();
        offer(4'd2, 4'd1, 4'd0, 4'd0);
        tick();
        offer(4'd2, 4'd2, 4'd0, 4'd0);
        tick();
        idle_inputs();
        // inst_2 alone: no pop, error set.
        inst_2_fetch = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL oo_count: got %0d expected 2", count); end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL oo_err: got %0b expected 1", proto_err); end
        n_checks++; if (inst_1_dest !== 4'd1) begin n_fail++; $display("FAIL oo_head: got %0d expected 1", inst_1_dest); end
        // Legal single fetch: error stays sticky.
        inst_1_fetch = 1'b1;
        tick();
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL legal_count: got %0d expected 1", count); end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b expected 1", proto_err); end
        // Both fetches with one entry: inst_2 part ignored, one pop.
        inst_2_fetch = 1'b1;
        tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL half_pop_count: got %0d expected 0", count); end
        // Empty: push with fetch -> fetch ignored, push lands.
        offer(4'd3, 4'd7, 4'd0, 4'd0);
        tick();
        idle_inputs();
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL empty_push_fetch_count: got %0d expected 1", count); end
        n_checks++; if ({inst_1_type, inst_1_dest} !== 8'h37) begin n_fail++; $display("FAIL empty_push_fetch_head: got %h expected 37", {inst_1_type, inst_1_dest}); end
    endtask

    task automatic test_flush();
        // Continues from count=1 with proto_err set.
        for (int i = 0; i < 4; i++) begin
            offer(4'd1, 4'(i), 4'd0, 4'd0);
            tick();
        end
        idle_inputs();
        n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL preflush_count: got %0d expected 5", count); end
        flush        = 1'b1;
        inst_1_fetch = 1'b1;
        inst_2_fetch = 1'b1;
        offer(4'd1, 4'd9, 4'd0, 4'd0);
        tick();
        idle_inputs();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_checks++; if ({inst_1_valid, inst_2_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_valids: got %b expected 00", {inst_1_valid, inst_2_valid}); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b expected 1", in_ready); end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_err: got %0b expected 1", proto_err); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            offer(4'd2, 4'(i + 4), 4'd0, 4'd0);
            tick();
        end
        idle_inputs();
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL prereset_count: got %0d expected 3", count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({inst_1_valid, inst_2_valid} !== 2'b00) begin n_fail++; $display("FAIL async_valids: got %b expected 00", {inst_1_valid, inst_2_valid}); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", count); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL async_err: got %0b expected 0", proto_err); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if ({count, inst_1_valid, in_ready} !== 6'b000001) begin
            n_fail++; $display("FAIL post_reset_empty: got %b expected 000001", {count, inst_1_valid, in_ready});
        end
    endtask

    initial begin
        test_reset();
        test_push_one();
        test_fill_and_wrap();
        test_proto_err();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
